// File: rtl/dmem_pkg.sv
// dmem_pkg: shared access-size and FSM state encodings for dmem_responder
package dmem_pkg;
  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10, RSVD = 2'b11} size_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: load lane extraction/extension and store lane/byte-enable generation
// DMEM_MISALIGN_ERR_EN flags misaligned half/word accesses instead of forcing alignment
module dmem_lane_align import dmem_pkg::*; (
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        zext,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] wlane,
  output logic [3:0]  be,
  output logic        align_err
);
  logic [1:0]  lane;
  logic [31:0] sh;
  always_comb begin
    lane = size == HALF ? {offset[1], 1'b0} : size == WORD ? 2'b00 : offset;
    sh = word >> {lane, 3'b000};
    rdata = size == BYTE ? {{24{~zext & sh[7]}}, sh[7:0]} :
            size == HALF ? {{16{~zext & sh[15]}}, sh[15:0]} : sh;
    wlane = wdata << {lane, 3'b000};
    be = (size == BYTE ? 4'b0001 : size == HALF ? 4'b0011 : size == WORD ? 4'b1111 : 4'b0000) << lane;
`ifdef DMEM_MISALIGN_ERR_EN
    align_err = (size == HALF && offset[0]) || (size == WORD && offset != 2'b00);
`else
    align_err = 1'b0;
`endif
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data memory with fixed response latency
// DMEM_MISALIGN_ERR_EN (optional) turns misaligned half/word accesses into errors
module dmem_responder import dmem_pkg::*; #(
  parameter int          DEPTH_WORDS = 16384,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_rw,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int          IW     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT  = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
  state_e state;
  logic [3:0] cnt;
  logic [31:0] addr_q, wdata_q, addr, wdata, off, ld_data, wlane;
  logic [1:0] size_q, size;
  logic rw_q, zext_q, rw, zext, err, align_err, enter_resp;
  logic [3:0] be;
  logic [IW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];
  assign req_ready = state == IDLE;
  // with LATENCY==1 RESP is entered on the accept edge, so the access must use the live request
  always_comb begin
    addr = req_ready ? req_addr : addr_q;
    wdata = req_ready ? req_wdata : wdata_q;
    size = req_ready ? req_size : size_q;
    rw = req_ready ? req_rw : rw_q;
    zext = req_ready ? req_unsigned : zext_q;
    off = addr - BASE_ADDR;
    idx = off[IW+1:2];
    err = off >= LIMIT || size == RSVD || align_err;
    enter_resp = (req_ready && req_valid && LATENCY == 1) || (state == WAIT && cnt == 4'd0);
  end
  dmem_lane_align u_align (
    .size(size), .offset(addr[1:0]), .zext(zext), .word(mem[idx]), .wdata(wdata),
    .rdata(ld_data), .wlane(wlane), .be(be), .align_err(align_err)
  );
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q <= req_addr;
          wdata_q <= req_wdata;
          size_q <= req_size;
          rw_q <= req_rw;
          zext_q <= req_unsigned;
          cnt <= LAT_M1;
          state <= LATENCY == 1 ? RESP : WAIT;
        end
        WAIT: if (cnt == 4'd0) state <= RESP; else cnt <= cnt - 4'd1;
        RESP: if (rsp_ready) begin
          state <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_err <= err;
        rsp_rdata <= err || rw ? 32'd0 : ld_data;
      end
    end
  end
  always_ff @(posedge clock)
    if (reset && enter_resp && !err && rw)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized scoreboard bench against a byte-addressed reference model
module tb_dmem_responder;
  localparam int          DEPTH = 16384;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0100_0000;
  typedef struct {logic [31:0] rdata; logic err;} exp_t;
  logic clock = 0, reset = 0, req_valid = 0, req_rw = 0, req_unsigned = 0, rsp_ready = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata;
  logic [1:0] req_size = 0;
  exp_t exp_q[$];
  int acc_q[$];
  logic [7:0] bm [logic [31:0]];
  int total = 0, bad = 0, ncyc = 0;
  bit hold = 0, prev_v = 0, prev_hold = 0;
  logic [31:0] held_d, last_rdata = 0;
  logic held_e, last_err = 0;
  always #5 clock = ~clock;
  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endfunction
  // memory as a flat little-endian byte map; accesses are aligned down to their natural size
  function automatic exp_t model(logic [31:0] a, logic rw, logic [31:0] wd, logic [1:0] sz, logic un);
    exp_t e;
    logic [31:0] off = a - BASE;
    int n = 1 << sz;
    logic [31:0] ea;
    longint v = 0;
    e.rdata = 0;
    e.err = off >= 32'(4 * DEPTH) || sz == 2'b11;
`ifdef DMEM_MISALIGN_ERR_EN
    e.err = e.err || (a % 32'(n)) != 0;
`endif
    if (e.err) return e;
    ea = a - (a % 32'(n));
    if (rw) begin
      for (int i = 0; i < n; i++) bm[ea + 32'(i)] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) v = v | (longint'(bm[ea + 32'(i)]) << (8 * i));
      if (!un && v[8*n-1]) v = v - (longint'(1) << (8 * n));
      e.rdata = v[31:0];
    end
    return e;
  endfunction
  initial forever begin
    @(posedge clock);
    #1 rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end
  always @(negedge clock) begin
    exp_t e;
    int a;
    ncyc++;
    if (!reset) begin
      acc_q.delete();
      prev_v = 0;
      prev_hold = 0;
    end else begin
      if (req_valid && req_ready) begin
        chk("accept_while_rsp", {31'd0, rsp_valid}, 32'd0);
        acc_q.push_back(ncyc);
      end
      if (rsp_valid && !prev_v) begin
        if (acc_q.size() == 0) chk("spurious_rsp", 32'd1, 32'd0);
        else begin
          a = acc_q.pop_front();
          chk("latency", 32'(ncyc - a - 1), 32'(LAT));
        end
      end
      if (prev_hold) begin
        chk("hold_rdata", rsp_rdata, held_d);
        chk("hold_err", {31'd0, rsp_err}, {31'd0, held_e});
        chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("rdata", rsp_rdata, e.rdata);
          chk("err", {31'd0, rsp_err}, {31'd0, e.err});
        end
        last_rdata = rsp_rdata;
        last_err = rsp_err;
      end
      prev_v = rsp_valid;
      prev_hold = rsp_valid && !rsp_ready;
      held_d = rsp_rdata;
      held_e = rsp_err;
    end
  end
  task automatic send(input logic [31:0] a, input logic rw, input logic [31:0] wd,
                      input logic [1:0] sz, input logic un, input bit abort);
    int t = 0;
    @(posedge clock);
    #1;
    req_valid = 1; req_addr = a; req_rw = rw; req_wdata = wd; req_size = sz; req_unsigned = un;
    while (!req_ready && t < 100) begin
      @(posedge clock);
      #1 t++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 0;
      return;
    end
    @(posedge clock);
    if (!abort) exp_q.push_back(model(a, rw, wd, sz, un));
    #1 req_valid = 0;
    if (abort) begin
      reset = 0;
      @(posedge clock);
      #1 reset = 1;
      @(negedge clock);
      chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
      chk("valid_after_rst", {31'd0, rsp_valid}, 32'd0);
    end
  endtask
  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'd0, 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] a;
    int mode;
    repeat (3) @(posedge clock);
    #1 reset = 1;
    @(negedge clock);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    for (int i = 0; i < 64; i++) send(BASE + 32'(4 * i), 1'b1, $urandom, 2'b10, 1'b0, 1'b0);
    send(BASE + 32'h10, 1'b1, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0);
    send(BASE + 32'h10, 1'b0, 32'd0, 2'b10, 1'b0, 1'b0);
    drain();
    chk("word_read", last_rdata, 32'hDEADBEEF);
    send(BASE + 32'h13, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
    drain();
    chk("byte_signed", last_rdata, 32'hFFFF_FFDE);
    send(BASE + 32'h13, 1'b0, 32'd0, 2'b00, 1'b1, 1'b0);
    drain();
    chk("byte_unsigned", last_rdata, 32'h0000_00DE);
    send(BASE + 32'h10, 1'b0, 32'd0, 2'b01, 1'b0, 1'b0);
    drain();
    chk("half_signed", last_rdata, 32'hFFFF_BEEF);
    send(32'h00FF_FFFC, 1'b0, 32'd0, 2'b10, 1'b0, 1'b0);
    drain();
    chk("below_base_err", {31'd0, last_err}, 32'd1);
    chk("below_base_rdata", last_rdata, 32'd0);
    send(32'h0101_0000, 1'b0, 32'd0, 2'b10, 1'b0, 1'b0);
    drain();
    chk("above_top_err", {31'd0, last_err}, 32'd1);
    chk("above_top_rdata", last_rdata, 32'd0);
    send(BASE + 32'h10, 1'b0, 32'd0, 2'b11, 1'b0, 1'b0);
    drain();
    chk("rsvd_err", {31'd0, last_err}, 32'd1);
    send(BASE + 32'h12, 1'b0, 32'd0, 2'b10, 1'b0, 1'b0);
    drain();
`ifdef DMEM_MISALIGN_ERR_EN
    chk("misalign_err", {31'd0, last_err}, 32'd1);
`else
    chk("misalign_forced", last_rdata, 32'hDEADBEEF);
`endif
    hold = 1;
    send(BASE + 32'h10, 1'b0, 32'd0, 2'b10, 1'b0, 1'b0);
    fork
      send(BASE + 32'h14, 1'b0, 32'd0, 2'b10, 1'b1, 1'b0);
      begin
        repeat (2) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
          @(negedge clock);
          chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
          chk("stall_ready", {31'd0, req_ready}, 32'd0);
        end
        hold = 0;
      end
    join
    drain();
    send(BASE + 32'h20, 1'b1, 32'hA5A5_A5A5, 2'b10, 1'b0, 1'b0);
    drain();
    send(BASE + 32'h20, 1'b1, 32'h1234_5678, 2'b10, 1'b0, 1'b1);
    send(BASE + 32'h20, 1'b0, 32'd0, 2'b10, 1'b0, 1'b0);
    drain();
    chk("abort_no_write", last_rdata, 32'hA5A5_A5A5);
    for (int i = 0; i < 300; i++) begin
      mode = $urandom_range(0, 9);
      a = mode == 0 ? BASE - 32'($urandom_range(1, 64)) :
          mode == 1 ? BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 64)) :
          BASE + 32'($urandom_range(0, 255));
      send(a, 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end
    drain();
    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 16384, giving the storage size in 32-bit words.
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the cycles from request accept to rsp_valid, legal range 1..15.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0100_0000, giving the byte address of word 0.
REQ-004 The block SHALL have port clock, input, width 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, width 1, synchronous and active-low.
REQ-006 The block SHALL have port req_valid, input, width 1, asserted when the core presents a request.
REQ-007 The block SHALL have port req_ready, output, width 1, asserted when the block can accept a request.
REQ-008 The block SHALL have port req_addr, input, width 32, the byte address.
REQ-009 The block SHALL have port req_rw, input, width 1, where 1 = write and 0 = read.
REQ-010 The block SHALL have port req_wdata, input, width 32, the store data in its low-order bytes.
REQ-011 The block SHALL have port req_size, input, width 2, where 00 = byte, 01 = half, 10 = word, 11 = reserved (encoding equals funct3[1:0]).
REQ-012 The block SHALL have port req_unsigned, input, width 1, where 1 = zero-extend load data and 0 = sign-extend.
REQ-013 The block SHALL have port rsp_valid, output, width 1, asserted when a response is available.
REQ-014 The block SHALL have port rsp_ready, input, width 1, asserted when the core accepts the response.
REQ-015 The block SHALL have port rsp_rdata, output, width 32, the extended load data.
REQ-016 The block SHALL have port rsp_err, output, width 1, flagging a failed access.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, WAIT and RESP, with at most one request outstanding.
REQ-018 req_ready SHALL be 1 only in IDLE and SHALL be driven from the state register alone.
- No combinational path from req_* to rsp_*.
REQ-019 On req_valid && req_ready the block SHALL latch all req_* fields.
- Latency counter is loaded with LATENCY-1.
- Next state is WAIT, or RESP directly when LATENCY==1.
REQ-020 WAIT SHALL decrement the counter each cycle and move to RESP when it reaches 0.
- rsp_valid therefore rises exactly LATENCY cycles after the accept edge.
REQ-021 The storage access SHALL occur on the edge entering RESP.
- Write: byte enables commit to storage.
- Read: rsp_rdata is registered.
REQ-022 In RESP, rsp_valid SHALL be 1 with rsp_rdata and rsp_err held stable until rsp_ready is 1.
- The handshake edge returns the FSM to IDLE and clears rsp_valid.
REQ-023 Word index SHALL be (req_addr - BASE_ADDR) >> 2.
REQ-024 An address with (req_addr - BASE_ADDR) >= 4*DEPTH_WORDS, including an address below BASE_ADDR (wrapped), SHALL respond with rsp_err=1 and rsp_rdata=0, with no write.
REQ-025 Reads SHALL shift the word right by 8*req_addr[1:0] and take 8, 16 or 32 bits per req_size.
- The result is extended per req_unsigned.
REQ-026 Writes SHALL place req_wdata low bytes at the addressed lanes only and SHALL return rsp_rdata=0, rsp_err=0.
REQ-027 req_size=11 SHALL respond with rsp_err=1 and rsp_rdata=0, with no write.
REQ-028 req_valid while not in IDLE SHALL be ignored, and the request SHALL remain pending at the core.

Reset
REQ-029 While reset is 0 at an edge, the block SHALL set state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- req_ready reads 1 after that edge.
REQ-030 Reset in WAIT SHALL abandon the request, with no write committed.
- Reset in RESP discards the pending response; storage keeps any committed write.
REQ-031 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-032 With macro DMEM_MISALIGN_ERR_EN defined, misaligned accesses SHALL respond with rsp_err=1, rsp_rdata=0, with no write.
- Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
REQ-033 Without DMEM_MISALIGN_ERR_EN, alignment SHALL be forced and rsp_err SHALL never be set by alignment.
- Half ignores addr[0] and uses addr[1].
- Word ignores addr[1:0].

Structure
REQ-034 Shared package dmem_pkg SHALL hold the access-size enum (BYTE, HALF, WORD, RSVD) and the FSM state enum.
REQ-035 Lane shifting, extension and byte-enable generation SHALL live in one combinational sub-module, dmem_lane_align.

Verification
REQ-036 Write word 32'hDEADBEEF at 32'h0100_0010, then read word there -> rsp_rdata=32'hDEADBEEF, rsp_valid exactly 2 cycles after each accept.
REQ-037 After REQ-036, read byte at 32'h0100_0013, signed -> 32'hFFFF_FFDE; unsigned -> 32'h0000_00DE; read half at 32'h0100_0010, signed -> 32'hFFFF_BEEF.
REQ-038 Read at 32'h00FF_FFFC, then at 32'h0101_0000 (DEPTH_WORDS=16384) -> both rsp_err=1, rsp_rdata=0; req_size=11 -> rsp_err=1.
REQ-039 Hold rsp_ready=0 for 5 cycles with a second req_valid pending -> rsp_* stable, req_ready=0, second request accepted only after the rsp handshake.
REQ-040 Apply reset=0 one cycle after accepting a word write of 32'h1234_5678 to 32'h0100_0020 -> rsp_valid=0, req_ready=1 after reset, and a later read returns the old value.
REQ-041 With the macro defined, word read at 32'h0100_0012 -> rsp_err=1; without it -> the word at 32'h0100_0010.
